// File: rtl/dp_mc_pkg.sv
// Shared types and constants for the multicycle datapath.
package dp_mc_pkg;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_e;

    typedef enum logic [1:0] {WS_ALU, WS_MEM, WS_PC4, WS_RSV} wsrc_e;
    typedef enum logic [1:0] {PC_SEQ, PC_JAL, PC_JALR, PC_RSV} pcsrc_e;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_LT} branch_e;
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB} state_e;

    localparam int REG_A0  = 10;
    localparam int PC_STEP = 4;

endpackage

// File: rtl/datapath_mc_alu.sv
// Combinational ALU: arithmetic/logic result plus rs1-vs-rs2 compare flags.
module alu_n
    import dp_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] cmp_i,
    input  alu_op_e         op_i,
    output logic [XLEN-1:0] result_o,
    output logic            eq_o,
    output logic            lt_o
);
    localparam int SHW = $clog2(XLEN);

    logic slt;
    assign slt = $signed(a_i) < $signed(b_i);

    // Result mux; shifts only honour the low SHW bits of the operand.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, slt};
            ALU_SLL: result_o = a_i << b_i[SHW-1:0];
            ALU_SRL: result_o = a_i >> b_i[SHW-1:0];
            default: result_o = '0;
        endcase
    end

    // Branch flags always compare rs1 against rs2, never the immediate.
    assign eq_o = (a_i == cmp_i);
    assign lt_o = $signed(a_i) < $signed(cmp_i);

endmodule

// File: rtl/datapath_mc.sv
// Multicycle datapath: IDLE -> EXEC -> [MEM_REQ -> MEM_WAIT] -> WB per instruction.
module datapath_mc
    import dp_mc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              NUM_REGS   = 32,
    parameter int              ADDR_WIDTH = 5,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic                  RegWrite_i,
    input  logic [1:0]            WriteSrc_i,
    input  logic [1:0]            PCsrc_i,
    input  logic [1:0]            Branch_i,
    input  logic                  ALUsrc_i,
    input  logic [2:0]            ALUctrl_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [XLEN-1:0]       Imm_i,
    input  logic [XLEN-1:0]       PC_i,
    output logic                  EQ_o,
    output logic                  LT_o,
    output logic [XLEN-1:0]       nextPC_o,
    output logic [XLEN-1:0]       a0_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [XLEN-1:0]       mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i
);
    state_e                state_q, state_d;
    logic [XLEN-1:0]       rf_q [NUM_REGS];
    logic [XLEN-1:0]       rs1v_q, rs2v_q, imm_q, pc_q, alu_q, rdata_q, npc_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  regwrite_q, alusrc_q, memrd_q, memwr_q, eq_q, lt_q;
    wsrc_e                 wsrc_q;
    pcsrc_e                pcsrc_q;
    branch_e               br_q;
    alu_op_e               aluop_q;

    logic [XLEN-1:0] alu_res, npc_d, wb_val, pc4, pc_imm, jalr_sum;
    logic            alu_eq, alu_lt, br_taken, rd_cap;

    alu_n #(.XLEN(XLEN)) u_alu (
        .a_i      (rs1v_q),
        .b_i      (alusrc_q ? imm_q : rs2v_q),
        .cmp_i    (rs2v_q),
        .op_i     (aluop_q),
        .result_o (alu_res),
        .eq_o     (alu_eq),
        .lt_o     (alu_lt)
    );

    assign pc4      = pc_q + XLEN'(PC_STEP);
    assign pc_imm   = pc_q + imm_q;
    assign jalr_sum = rs1v_q + imm_q;

    // A store wins when both MemRead and MemWrite are set, so loads never see memwr_q.
    assign rd_cap = (state_q == S_MEM_REQ && mem_gnt_i && mem_rvalid_i && !memwr_q)
                 || (state_q == S_MEM_WAIT && mem_rvalid_i);

    // Branch resolution and next-PC selection from the registered EXEC flags.
    always_comb begin
        br_taken = 1'b0;
        npc_d    = pc4;
        case (br_q)
            BR_EQ:   br_taken = eq_q;
            BR_NE:   br_taken = !eq_q;
            BR_LT:   br_taken = lt_q;
            default: br_taken = 1'b0;
        endcase
        case (pcsrc_q)
            PC_JAL:  npc_d = pc_imm;
            PC_JALR: npc_d = {jalr_sum[XLEN-1:1], 1'b0};
            default: npc_d = br_taken ? pc_imm : pc4;
        endcase
    end

    // Write-back source select; the reserved encoding falls back to the ALU result.
    always_comb begin
        wb_val = alu_q;
        case (wsrc_q)
            WS_MEM:  wb_val = rdata_q;
            WS_PC4:  wb_val = pc4;
            default: wb_val = alu_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs; unknown states recover to IDLE.
    always_comb begin
        state_d   = state_q;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        mem_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = S_EXEC;
            end
            S_EXEC:     state_d = (memrd_q || memwr_q) ? S_MEM_REQ : S_WB;
            S_MEM_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_d = (memwr_q || mem_rvalid_i) ? S_WB : S_MEM_WAIT;
            end
            S_MEM_WAIT: if (mem_rvalid_i) state_d = S_WB;
            S_WB: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Instruction latch, EXEC results, load capture and PC update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1v_q <= '0; rs2v_q <= '0; imm_q <= '0; pc_q <= '0; rd_q <= '0;
            regwrite_q <= 1'b0; alusrc_q <= 1'b0; memrd_q <= 1'b0; memwr_q <= 1'b0;
            wsrc_q <= WS_ALU; pcsrc_q <= PC_SEQ; br_q <= BR_NONE; aluop_q <= ALU_ADD;
            alu_q <= '0; eq_q <= 1'b0; lt_q <= 1'b0; rdata_q <= '0; npc_q <= RESET_PC;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                rs1v_q     <= (rs1_i == '0) ? '0 : rf_q[rs1_i];
                rs2v_q     <= (rs2_i == '0) ? '0 : rf_q[rs2_i];
                imm_q      <= Imm_i;
                pc_q       <= PC_i;
                rd_q       <= rd_i;
                regwrite_q <= RegWrite_i;
                alusrc_q   <= ALUsrc_i;
                memrd_q    <= MemRead_i;
                memwr_q    <= MemWrite_i;
                wsrc_q     <= wsrc_e'(WriteSrc_i);
                pcsrc_q    <= pcsrc_e'(PCsrc_i);
                br_q       <= branch_e'(Branch_i);
                aluop_q    <= alu_op_e'(ALUctrl_i);
            end
            if (state_q == S_EXEC) begin
                alu_q <= alu_res;
                eq_q  <= alu_eq;
                lt_q  <= alu_lt;
            end
            if (rd_cap) rdata_q <= mem_rdata_i;
            if (state_q == S_WB) npc_q <= npc_d;
        end
    end

    // Register file; x0 is never written so it always reads back zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (state_q == S_WB && regwrite_q && rd_q != '0) begin
            rf_q[rd_q] <= wb_val;
        end
    end

    assign mem_we_o    = mem_req_o && memwr_q;
    assign mem_addr_o  = alu_q;
    assign mem_wdata_o = rs2v_q;
    assign EQ_o        = eq_q;
    assign LT_o        = lt_q;
    assign nextPC_o    = npc_q;
    assign a0_o        = rf_q[REG_A0];

endmodule

// File: tb/tb_datapath_mc.sv
// Scoreboard bench for datapath_mc: driver pushes expectations, monitor checks on done_o.
module tb_datapath_mc;

    logic        clk = 0, rst_n = 0, start_i = 0;
    logic        busy_o, done_o, EQ_o, LT_o, mem_req_o, mem_we_o;
    logic [4:0]  rs1_i = 0, rs2_i = 0, rd_i = 0;
    logic        RegWrite_i = 0, ALUsrc_i = 0, MemRead_i = 0, MemWrite_i = 0;
    logic [1:0]  WriteSrc_i = 0, PCsrc_i = 0, Branch_i = 0;
    logic [2:0]  ALUctrl_i = 0;
    logic [31:0] Imm_i = 0, PC_i = 0, nextPC_o, a0_o, mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 0, mem_rvalid_i = 0;
    logic [31:0] mem_rdata_i = 0;

    datapath_mc dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .RegWrite_i(RegWrite_i),
        .WriteSrc_i(WriteSrc_i), .PCsrc_i(PCsrc_i), .Branch_i(Branch_i),
        .ALUsrc_i(ALUsrc_i), .ALUctrl_i(ALUctrl_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .Imm_i(Imm_i), .PC_i(PC_i), .EQ_o(EQ_o), .LT_o(LT_o),
        .nextPC_o(nextPC_o), .a0_o(a0_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rw;
        logic [1:0]  ws, pcs, br;
        logic        as;
        logic [2:0]  op;
        logic        mr, mw;
        logic [31:0] imm, pc;
    } instr_t;

    typedef struct {
        logic [31:0] a0, npc;
        logic        eq, lt, cc;
        int          lat, issue;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;

    // Memory responder settings, written by the driver before each instruction.
    int          gnt_dly = 0, rv_dly = 0;
    logic [31:0] rd_val = 0, e_addr = 0, e_wdata = 0;
    logic        e_we = 0;

    localparam logic [2:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SLT = 5, SLL = 6, SRL = 7;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rs1, rs2, rd, input logic rw,
                                  input logic [1:0] ws, pcs, br, input logic as,
                                  input logic [2:0] op, input logic mr, mw,
                                  input logic [31:0] imm, pc);
        instr_t t;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.ws = ws; t.pcs = pcs; t.br = br;
        t.as = as; t.op = op; t.mr = mr; t.mw = mw; t.imm = imm; t.pc = pc;
        return t;
    endfunction

    function automatic exp_t ex(input logic [31:0] a0, npc, input logic eq, lt, cc, input int lat);
        exp_t e;
        e.a0 = a0; e.npc = npc; e.eq = eq; e.lt = lt; e.cc = cc; e.lat = lat; e.issue = 0;
        return e;
    endfunction

    task automatic drive(input instr_t t);
        rs1_i = t.rs1; rs2_i = t.rs2; rd_i = t.rd; RegWrite_i = t.rw; WriteSrc_i = t.ws;
        PCsrc_i = t.pcs; Branch_i = t.br; ALUsrc_i = t.as; ALUctrl_i = t.op;
        MemRead_i = t.mr; MemWrite_i = t.mw; Imm_i = t.imm; PC_i = t.pc;
        start_i = 1;
    endtask

    // Issue one instruction and wait (bounded) for its done_o; optionally pulse start while busy.
    task automatic go(input instr_t t, input exp_t e, input bit pulse = 0);
        bit seen = 0;
        @(negedge clk);
        drive(t);
        e.issue = cyc;
        sb.push_back(e);
        @(negedge clk);
        start_i = 0;
        for (int k = 0; k < 60; k++) begin
            if (done_o) begin
                start_i = 0;
                seen = 1;
                break;
            end
            chk("busy_while_running", {31'b0, busy_o}, 32'd1);
            if (pulse) start_i = k[0];
            @(negedge clk);
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done_o, expected one within 60 cycles");
        end
    endtask

    // Monitor: on done_o pop the scoreboard and check latency, flags, then committed state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done_o) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got done_o with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.issue, e.lat);
                    if (e.cc) begin
                        chk("EQ_o", {31'b0, EQ_o}, {31'b0, e.eq});
                        chk("LT_o", {31'b0, LT_o}, {31'b0, e.lt});
                    end
                    @(negedge clk);
                    chk("a0_o", a0_o, e.a0);
                    chk("nextPC_o", nextPC_o, e.npc);
                end
            end
        end
    end

    // Memory responder: checks the request and its stability, then grants / returns data.
    initial begin
        logic [31:0] a, w;
        logic        we;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_o === 1'b1) begin
                a = mem_addr_o; w = mem_wdata_o; we = mem_we_o;
                chk("mem_addr", a, e_addr);
                chk("mem_wdata", w, e_wdata);
                chk("mem_we", {31'b0, we}, {31'b0, e_we});
                for (int k = 0; k < gnt_dly; k++) begin
                    @(negedge clk);
                    chk("req_held", {31'b0, mem_req_o}, 32'd1);
                    chk("addr_held", mem_addr_o, a);
                    chk("wdata_held", mem_wdata_o, w);
                    chk("we_held", {31'b0, mem_we_o}, {31'b0, we});
                end
                mem_gnt_i = 1;
                if (!we && rv_dly == 0) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i  = rd_val;
                end
                @(negedge clk);
                mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
                chk("req_drops_after_gnt", {31'b0, mem_req_o}, 32'd0);
                if (!we && rv_dly > 0) begin
                    for (int k = 0; k < rv_dly - 1; k++) @(negedge clk);
                    mem_rvalid_i = 1;
                    mem_rdata_i  = rd_val;
                    @(negedge clk);
                    mem_rvalid_i = 0; mem_rdata_i = 0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_nextPC", nextPC_o, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_a0", a0_o, 32'h0);
        rst_n = 1;

        // Seed x1=5, x2=7 with ADDI, then ADD into a0.     rs1 rs2 rd rw ws pcs br as op mr mw imm pc
        go(mk(0, 0, 1, 1, 0, 0, 0, 1, ADD, 0, 0, 32'd5, 32'h0),  ex(32'h0, 32'h4, 1, 0, 1, 2));
        go(mk(0, 0, 2, 1, 0, 0, 0, 1, ADD, 0, 0, 32'd7, 32'h4),  ex(32'h0, 32'h8, 1, 0, 1, 2));
        go(mk(1, 2, 10, 1, 0, 0, 0, 0, ADD, 0, 0, 32'd0, 32'h10), ex(32'd12, 32'h14, 0, 1, 1, 2));
        // Write to x0 discarded, then read x0+x0 into a0.
        go(mk(1, 2, 0, 1, 0, 0, 0, 0, ADD, 0, 0, 32'd0, 32'h14), ex(32'd12, 32'h18, 0, 1, 1, 2));
        go(mk(0, 0, 10, 1, 0, 0, 0, 0, ADD, 0, 0, 32'd0, 32'h18), ex(32'd0, 32'h1C, 1, 0, 1, 2));
        // BNE taken (5 != 7), BEQ not taken.
        go(mk(1, 2, 0, 0, 0, 0, 2, 0, SUB, 0, 0, 32'hFFFF_FFF8, 32'h100), ex(32'd0, 32'hF8, 0, 1, 1, 2));
        go(mk(1, 2, 0, 0, 0, 0, 1, 0, SUB, 0, 0, 32'hFFFF_FFF8, 32'h100), ex(32'd0, 32'h104, 0, 1, 1, 2));
        // x3=-1, x4=1; BLT taken for -1<1, not taken for 1<-1.
        go(mk(0, 0, 3, 1, 0, 0, 0, 1, ADD, 0, 0, 32'hFFFF_FFFF, 32'h0), ex(32'd0, 32'h4, 1, 0, 1, 2));
        go(mk(0, 0, 4, 1, 0, 0, 0, 1, ADD, 0, 0, 32'd1, 32'h0), ex(32'd0, 32'h4, 1, 0, 1, 2));
        go(mk(3, 4, 0, 0, 0, 0, 3, 0, SUB, 0, 0, 32'h20, 32'h200), ex(32'd0, 32'h220, 0, 1, 1, 2));
        go(mk(4, 3, 0, 0, 0, 0, 3, 0, SUB, 0, 0, 32'h20, 32'h200), ex(32'd0, 32'h204, 0, 0, 1, 2));
        // x5=0x203; JALR rd=1 -> nextPC 0x206, x1=0x44; read x1 back via a0; JAL.
        go(mk(0, 0, 5, 1, 0, 0, 0, 1, ADD, 0, 0, 32'h203, 32'h0), ex(32'd0, 32'h4, 1, 0, 1, 2));
        go(mk(5, 0, 1, 1, 2, 2, 0, 1, ADD, 0, 0, 32'd4, 32'h40), ex(32'd0, 32'h206, 0, 0, 1, 2));
        go(mk(1, 0, 10, 1, 0, 0, 0, 0, ADD, 0, 0, 32'd0, 32'h300), ex(32'h44, 32'h304, 0, 0, 1, 2));
        go(mk(0, 0, 0, 0, 0, 1, 0, 0, ADD, 0, 0, 32'h10, 32'h80), ex(32'h44, 32'h90, 1, 0, 1, 2));
        // Remaining ALU ops into a0 (shift amount uses only low 5 bits: 0x21 -> 1).
        go(mk(1, 0, 10, 1, 0, 0, 0, 1, SLL, 0, 0, 32'h21, 32'h0), ex(32'h88, 32'h4, 0, 0, 0, 2));
        go(mk(3, 0, 10, 1, 0, 0, 0, 1, SRL, 0, 0, 32'd4, 32'h0), ex(32'h0FFF_FFFF, 32'h4, 0, 0, 0, 2));
        go(mk(3, 4, 10, 1, 0, 0, 0, 0, SLT, 0, 0, 32'd0, 32'h0), ex(32'd1, 32'h4, 0, 0, 0, 2));
        go(mk(4, 3, 10, 1, 0, 0, 0, 0, SUB, 0, 0, 32'd0, 32'h0), ex(32'd2, 32'h4, 0, 0, 0, 2));
        go(mk(5, 0, 10, 1, 0, 0, 0, 1, AND_, 0, 0, 32'hF, 32'h0), ex(32'd3, 32'h4, 0, 0, 0, 2));
        go(mk(5, 0, 10, 1, 0, 0, 0, 1, OR_, 0, 0, 32'h10, 32'h0), ex(32'h213, 32'h4, 0, 0, 0, 2));
        go(mk(5, 0, 10, 1, 0, 0, 0, 1, XOR_, 0, 0, 32'h203, 32'h0), ex(32'h0, 32'h4, 0, 0, 0, 2));

        // Store, gnt held off 3 cycles: addr 0x203+1, wdata x4=1, no write to a0.
        gnt_dly = 3; rv_dly = 0; e_addr = 32'h204; e_wdata = 32'd1; e_we = 1;
        go(mk(5, 4, 10, 0, 0, 0, 0, 1, ADD, 0, 1, 32'd1, 32'h400), ex(32'h0, 32'h404, 0, 0, 0, 6));
        // Load with gnt and rvalid together.
        gnt_dly = 0; rv_dly = 0; rd_val = 32'hDEAD_BEEF; e_addr = 32'h100; e_wdata = 32'd0; e_we = 0;
        go(mk(0, 0, 10, 1, 1, 0, 0, 1, ADD, 1, 0, 32'h100, 32'h500), ex(32'hDEAD_BEEF, 32'h504, 0, 0, 0, 3));
        // Load with rvalid 5 cycles after gnt, start pulses while busy.
        gnt_dly = 0; rv_dly = 5; rd_val = 32'h1234_5678; e_addr = 32'h300; e_wdata = 32'd7; e_we = 0;
        go(mk(5, 2, 10, 1, 1, 0, 0, 1, ADD, 1, 0, 32'hFD, 32'h600), ex(32'h1234_5678, 32'h604, 0, 0, 0, 8), 1);

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        gnt_dly = 0; rv_dly = 20; rd_val = 32'hBAD0_BAD0; e_addr = 32'h40; e_wdata = 32'd0; e_we = 0;
        @(negedge clk);
        drive(mk(0, 0, 10, 1, 1, 0, 0, 1, ADD, 1, 0, 32'h40, 32'h700));
        @(negedge clk);
        start_i = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        chk("mrst_busy", {31'b0, busy_o}, 32'd0);
        chk("mrst_done", {31'b0, done_o}, 32'd0);
        chk("mrst_req", {31'b0, mem_req_o}, 32'd0);
        chk("mrst_we", {31'b0, mem_we_o}, 32'd0);
        chk("mrst_nextPC", nextPC_o, 32'h0);
        chk("mrst_a0", a0_o, 32'h0);
        chk("mrst_addr", mem_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1;
        repeat (30) @(negedge clk);
        chk("late_rvalid_a0", a0_o, 32'h0);
        chk("late_rvalid_busy", {31'b0, busy_o}, 32'd0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
Multicycle successor to the single-cycle datapath. It executes one decoded instruction per start/done handshake, with ALU, branch resolution and next-PC generation parametrised in XLEN and register count. Unlike the single-cycle block, loads and stores go through an external memory port with a req/gnt/rvalid handshake and variable latency. It sits between the control unit, which supplies decoded fields, and the data memory / PC register.

Parameters:
XLEN, 32, datapath and memory width
NUM_REGS, 32, architectural registers; x0 is hardwired to zero
ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS)
RESET_PC, 0, reset value of nextPC_o

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  decoded instruction valid; sampled only in IDLE
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse in WB
rs1_i, rs2_i, rd_i  in  ADDR_WIDTH each  register indices
RegWrite_i  in  1  write rd in WB
WriteSrc_i  in  2  0 ALU, 1 load data, 2 PC+4
PCsrc_i  in  2  0 sequential/branch, 1 JAL (PC+imm), 2 JALR
Branch_i  in  2  0 none, 1 BEQ, 2 BNE, 3 BLT (signed)
ALUsrc_i  in  1  0 rs2, 1 immediate
ALUctrl_i  in  3  ADD, SUB, AND, OR, XOR, SLT, SLL, SRL (codes 0-7)
MemRead_i, MemWrite_i  in  1 each  load/store; both set is illegal and is treated as store
Imm_i  in  XLEN  sign-extended immediate
PC_i  in  XLEN  PC of the current instruction
EQ_o, LT_o  out  1 each  registered rs1==rs2 and signed rs1<rs2
nextPC_o  out  XLEN  registered next PC
a0_o  out  XLEN  register 10
mem_req_o, mem_we_o  out  1 each  memory request and write enable
mem_addr_o, mem_wdata_o  out  XLEN each  memory address and write data
mem_gnt_i, mem_rvalid_i  in  1 each  request accepted / read data valid
mem_rdata_i  in  XLEN  load data

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE; all registers clear to 0, including the register file.
  - nextPC_o=RESET_PC; done_o, busy_o, mem_req_o, mem_we_o = 0.
  - An outstanding memory request is abandoned, and a late rvalid after reset is ignored.
- States: IDLE, EXEC, MEM_REQ, MEM_WAIT, WB.
- IDLE:
  - If start_i=1, latch all control inputs, Imm_i, PC_i and the register-file reads of rs1/rs2, then go to EXEC.
  - start_i is ignored in every other state.
- EXEC (one cycle):
  - Compute the ALU result; register it together with EQ_o and LT_o.
  - Shifts use the low clog2(XLEN) bits of the operand. SLT is signed. Arithmetic wraps modulo 2^XLEN.
  - Next state is MEM_REQ if MemRead or MemWrite is set, otherwise WB.
- MEM_REQ:
  - mem_req_o=1; mem_addr_o = ALU result; mem_we_o = MemWrite; mem_wdata_o = rs2.
  - All four outputs are held stable until mem_gnt_i=1.
  - On gnt: a store goes to WB. A load goes to MEM_WAIT, or straight to WB if mem_rvalid_i is also high in the same cycle (capture rdata).
  - mem_req_o drops in the cycle after gnt.
- MEM_WAIT: wait for mem_rvalid_i, then capture mem_rdata_i and go to WB. There is no timeout.
- WB (one cycle):
  - done_o=1.
  - If RegWrite and rd!=0, write the WriteSrc-selected value; the write is visible to the next instruction's read.
  - nextPC_o updates at the end of WB:
    - PCsrc=1: PC+imm.
    - PCsrc=2: (rs1+imm) with bit 0 cleared.
    - PCsrc=0: PC+imm if the branch condition holds, else PC+4.
  - Then return to IDLE.
- Writes to x0 are discarded; reads of x0 return 0.
- Latency, counted from the cycle start_i is sampled to the done_o cycle:
  - ALU/branch/jump: 2 cycles.
  - Store: 2 + gnt wait cycles + 1.
  - Load: adds the rvalid wait on top of the store latency.
- PCsrc=3 behaves as 0. Reserved encodings must not hang the FSM; an illegal state returns to IDLE.

Decomposition:
- Package dp_mc_pkg holds:
  - alu_op_e (3-bit), wsrc_e, pcsrc_e, branch_e, state_e;
  - constants REG_A0=10 and PC_STEP=4.
- One sub-module: alu_n #(XLEN), purely combinational, exporting result, eq and lt.
- The register file and the FSM stay inline.

Test Plan:
- ADD, then verify x0: reset; seed x1=5, x2=7; start ADD rd=10 (rs1=1, rs2=2).
  - -> done_o 2 cycles after start; a0_o=12; nextPC_o=PC_i+4.
  - Then ADD with rd=0 -> x0 still reads 0.
- BNE/BLT branches: BNE with x1=5, x2=7, PC=0x100, imm=-8 -> nextPC_o=0xF8, EQ_o=0. BLT with x1=-1, x2=1 -> taken, LT_o=1.
- JALR with rs1=0x203, imm=4, WriteSrc=2, rd=1, PC=0x40 -> nextPC_o=0x206; x1=0x44.
- Store with gnt held low 3 cycles -> req/addr/wdata stable for 4 cycles; done_o at cycle 6; no register written.
- Load with gnt and rvalid in the same cycle -> rdata 0xDEADBEEF written to rd. Load with rvalid 5 cycles after gnt -> busy_o high throughout; start_i pulses during busy are ignored.
- rst_n asserted in MEM_WAIT -> all outputs at reset values immediately; a later rvalid causes no write and no done_o.
